// File: rtl/pkt_fifo_ctrl_if.sv
// Beat stream between pipeline stages: payload, last-beat flag and keep/drop verdict.
interface pkt_fifo_ctrl_if #(
  parameter int DATA_W = 19
);
  logic [DATA_W-1:0] data;
  logic              eop;
  logic              drop;
  logic              valid;
  logic              ready;

  modport master (output data, eop, drop, valid, input ready);
  modport slave  (input data, eop, drop, valid, output ready);
endinterface

// File: rtl/pkt_fifo_ctrl.sv
// Store-and-forward packet controller: commits kept packets into an external FIFO,
// rewinds its write pointer to erase dropped/oversize packets, and streams out whole packets.
module pkt_fifo_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_W     = 19,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pkt_fifo_ctrl_if.slave        in_if,
  pkt_fifo_ctrl_if.master       out_if,
  output logic                  fifo_wen,
  output logic [DATA_W:0]       fifo_wdata,
  input  logic                  fifo_full,
  output logic                  fifo_wrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
  input  logic [ADDR_WIDTH:0]   fifo_wptr,
  output logic                  fifo_ren,
  input  logic [DATA_W:0]       fifo_rdata,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic [CNT_W-1:0]      drop_count,
  output logic [CNT_W-1:0]      ovf_count
);

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DISCARD, W_REWIND} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_VALID} rstate_e;

  wstate_e             wstate_q, wstate_d;
  rstate_e             rstate_q, rstate_d;
  logic [ADDR_WIDTH:0] start_ptr_q, start_ptr_d;
  logic [ADDR_WIDTH:0] pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0]    drop_count_q, drop_count_d;
  logic [CNT_W-1:0]    ovf_count_q, ovf_count_d;
  logic                in_rdy, out_vld;
  logic                commit, drop_pkt, ovf_pkt, rd_eop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Write side: every beat lands in the FIFO; the verdict decides commit or rewind
  always_comb begin
    wstate_d    = wstate_q;
    start_ptr_d = start_ptr_q;
    in_rdy      = 1'b0;
    fifo_wen    = 1'b0;
    fifo_wrst   = 1'b0;
    commit      = 1'b0;
    drop_pkt    = 1'b0;
    ovf_pkt     = 1'b0;
    case (wstate_q)
      W_IDLE, W_PKT: begin
        // Full with nothing committed means this packet alone exceeds the FIFO
        if (wstate_q == W_PKT && fifo_full && pkt_count_q == '0) begin
          ovf_pkt  = 1'b1;
          wstate_d = W_DISCARD;
        end else begin
          in_rdy = !fifo_full && !reset;
          if (in_if.valid && in_rdy) begin
            fifo_wen = 1'b1;
            if (wstate_q == W_IDLE) begin
              start_ptr_d = fifo_wptr;
              wstate_d    = W_PKT;
            end
            if (in_if.eop) begin
              if (in_if.drop) begin
                drop_pkt = 1'b1;
                wstate_d = W_REWIND;
              end else begin
                commit   = 1'b1;
                wstate_d = W_IDLE;
              end
            end
          end
        end
      end
      W_DISCARD: begin
        in_rdy = !reset;
        if (in_if.valid && in_rdy && in_if.eop) wstate_d = W_REWIND;
      end
      W_REWIND: begin
        fifo_wrst = 1'b1;
        wstate_d  = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read side: a fetch bubble lets the registered FIFO output catch up with the pointer
  always_comb begin
    rstate_d = rstate_q;
    out_vld  = 1'b0;
    fifo_ren = 1'b0;
    rd_eop   = 1'b0;
    case (rstate_q)
      R_IDLE:  if (pkt_count_q != '0) rstate_d = R_FETCH;
      R_FETCH: rstate_d = R_VALID;
      R_VALID: begin
        out_vld = 1'b1;
        if (out_if.ready) begin
          fifo_ren = 1'b1;
          if (fifo_rdata[DATA_W]) begin
            rd_eop   = 1'b1;
            rstate_d = R_IDLE;
          end else begin
            rstate_d = R_FETCH;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (commit && !rd_eop)      pkt_count_d = pkt_count_q + (ADDR_WIDTH+1)'(1);
    else if (rd_eop && !commit) pkt_count_d = pkt_count_q - (ADDR_WIDTH+1)'(1);
    drop_count_d = drop_pkt ? sat_inc(drop_count_q) : drop_count_q;
    ovf_count_d  = ovf_pkt  ? sat_inc(ovf_count_q)  : ovf_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      start_ptr_q  <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      ovf_count_q  <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      start_ptr_q  <= start_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign in_if.ready   = in_rdy;
  assign out_if.valid  = out_vld;
  assign out_if.data   = out_vld ? fifo_rdata[DATA_W-1:0] : '0;
  assign out_if.eop    = out_vld & fifo_rdata[DATA_W];
  assign out_if.drop   = 1'b0;
  assign fifo_wdata    = fifo_wen ? {in_if.eop, in_if.data} : '0;
  assign fifo_rst_wptr = fifo_wrst ? start_ptr_q : '0;
  assign pkt_count     = pkt_count_q;
  assign drop_count    = drop_count_q;
  assign ovf_count     = ovf_count_q;

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Directed bench for pkt_fifo_ctrl with a 16-entry FIFO model using a resettable write pointer.
module tb_pkt_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 12;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  logic out_ready;
  logic          fifo_wen, fifo_full, fifo_wrst, fifo_ren;
  logic [DW:0]   fifo_wdata, fifo_rdata;
  logic [AW:0]   fifo_rst_wptr, fifo_wptr, rptr;
  logic [AW:0]   pkt_count;
  logic [CW-1:0] drop_count, ovf_count;
  logic [DW:0]   mem [0:(1<<AW)-1];

  pkt_fifo_ctrl_if #(.DATA_W(DW)) in_if ();
  pkt_fifo_ctrl_if #(.DATA_W(DW)) out_if ();

  assign out_if.ready = out_ready;

  pkt_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_if(in_if), .out_if(out_if),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_wrst(fifo_wrst), .fifo_rst_wptr(fifo_rst_wptr), .fifo_wptr(fifo_wptr),
    .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata), .pkt_count(pkt_count),
    .drop_count(drop_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, write pointer can be rewound
  assign fifo_full = ((fifo_wptr - rptr) == (AW+1)'(1 << AW));
  always @(posedge clk) begin
    if (reset) begin
      fifo_wptr  <= '0;
      rptr       <= '0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_wrst) fifo_wptr <= fifo_rst_wptr;
      else if (fifo_wen && !fifo_full) begin
        mem[fifo_wptr[AW-1:0]] <= fifo_wdata;
        fifo_wptr <= fifo_wptr + (AW+1)'(1);
      end
      if (fifo_ren) rptr <= rptr + (AW+1)'(1);
      fifo_rdata <= mem[rptr[AW-1:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW:0] rx_q [$];
  int          rx_cyc [$];
  int          wrst_n = 0, wen_n = 0, viol_n = 0, pk_max = 0;
  logic [AW:0] last_rst_ptr = '0;
  logic        hold_prev = 1'b0;
  logic [DW:0] beat_prev = '0;

  always @(negedge clk) begin
    if (out_if.valid && out_ready) begin
      rx_q.push_back({out_if.eop, out_if.data});
      rx_cyc.push_back(cyc);
    end
    if (fifo_wrst) begin
      wrst_n       = wrst_n + 1;
      last_rst_ptr = fifo_rst_wptr;
    end
    if (fifo_wen) wen_n = wen_n + 1;
    if (fifo_wen && (fifo_wrst || fifo_full)) viol_n = viol_n + 1;
    if (hold_prev && out_if.valid && ({out_if.eop, out_if.data} != beat_prev)) viol_n = viol_n + 1;
    hold_prev = out_if.valid && !out_ready;
    beat_prev = {out_if.eop, out_if.data};
    if (reset) pk_max = 0;
    else if (int'(pkt_count) > pk_max) pk_max = int'(pkt_count);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    in_if.valid  = 1'b0;
    in_if.eop    = 1'b0;
    in_if.drop   = 1'b0;
    in_if.data   = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int n, input logic drop, input int base);
    int w;
    for (int i = 0; i < n; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = DW'(base + i);
      in_if.eop   = (i == n - 1);
      in_if.drop  = drop;
      w = 0;
      @(negedge clk);
      while (!in_if.ready && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) begin
        chk($sformatf("send_ready_0x%0h", base + i), 32'(in_if.ready), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    in_if.valid = 1'b0;
    in_if.eop   = 1'b0;
    in_if.drop  = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int w = 0;
    while (rx_q.size() < n && w < 2000) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic chk_beats(input string tag, input int idx, input int base, input int n);
    for (int j = 0; j < n; j++)
      chk($sformatf("%s_beat%0d", tag, j), 32'(rx_q[idx + j]),
          32'(((j == n - 1) ? (1 << DW) : 0) + base + j));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int  rb, wb, nb;
  logic s_done;

  initial begin
    out_ready   = 1'b0;
    reset       = 1'b1;
    in_if.valid = 1'b0;
    in_if.eop   = 1'b0;
    in_if.drop  = 1'b0;
    in_if.data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_if.ready),  32'd0);
    chk("rst_out_valid", 32'(out_if.valid), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count),    32'd0);
    chk("rst_drop",      32'(drop_count),   32'd0);
    chk("rst_ovf",       32'(ovf_count),    32'd0);
    chk("rst_wrst",      32'(fifo_wrst),    32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_if.ready), 32'd1);

    // three 4-beat kept packets
    out_ready = 1'b1;
    rb = rx_q.size();
    send_pkt(4, 1'b0, 'h10);
    send_pkt(4, 1'b0, 'h20);
    send_pkt(4, 1'b0, 'h30);
    wait_rx(rb + 12);
    chk_beats("t1a", rb,     'h10, 4);
    chk_beats("t1b", rb + 4, 'h20, 4);
    chk_beats("t1c", rb + 8, 'h30, 4);
    chk("t1_gap", 32'(rx_cyc[rb + 1] - rx_cyc[rb]), 32'd2);
    chk("t1_pk_max", 32'(pk_max), 32'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_pkt_count_end", 32'(pkt_count), 32'd0);

    // keep A, drop B, keep C
    apply_reset();
    rb = rx_q.size();
    wb = wrst_n;
    send_pkt(3, 1'b0, 'h100);
    send_pkt(5, 1'b1, 'h200);
    send_pkt(2, 1'b0, 'h300);
    wait_rx(rb + 5);
    repeat (12) @(posedge clk);
    #1;
    chk("t2_rx_total", 32'(rx_q.size()), 32'(rb + 5));
    chk_beats("t2a", rb,     'h100, 3);
    chk_beats("t2c", rb + 3, 'h300, 2);
    chk("t2_wrst_pulses", 32'(wrst_n - wb), 32'd1);
    chk("t2_rst_ptr", 32'(last_rst_ptr), 32'd3);
    chk("t2_drop_count", 32'(drop_count), 32'd1);

    // oversize packet into an empty FIFO
    apply_reset();
    rb = rx_q.size();
    wb = wrst_n;
    nb = wen_n;
    send_pkt(20, 1'b0, 'h400);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_ovf_count", 32'(ovf_count), 32'd1);
    chk("t3_wen_beats", 32'(wen_n - nb), 32'd16);
    chk("t3_wrst_pulses", 32'(wrst_n - wb), 32'd1);
    chk("t3_rst_ptr", 32'(last_rst_ptr), 32'd0);
    chk("t3_wptr", 32'(fifo_wptr), 32'd0);
    chk("t3_no_egress", 32'(rx_q.size()), 32'(rb));
    send_pkt(2, 1'b0, 'h500);
    wait_rx(rb + 2);
    chk_beats("t3k", rb, 'h500, 2);
    chk("t3_drop_count", 32'(drop_count), 32'd0);

    // backpressure: committed 10-beat packet plus 8-beat packet, egress stalled
    apply_reset();
    out_ready = 1'b0;
    rb = rx_q.size();
    send_pkt(10, 1'b0, 'h600);
    s_done = 1'b0;
    fork
      begin
        send_pkt(8, 1'b0, 'h700);
        s_done = 1'b1;
      end
    join_none
    repeat (20) @(posedge clk);
    #1;
    chk("t4_in_ready", 32'(in_if.ready), 32'd0);
    chk("t4_wptr_full", 32'(fifo_wptr), 32'd16);
    chk("t4_ovf_count", 32'(ovf_count), 32'd0);
    chk("t4_pkt_count", 32'(pkt_count), 32'd1);
    out_ready = 1'b1;
    wait (s_done || cyc > 40000);
    wait_rx(rb + 18);
    chk_beats("t4a", rb,      'h600, 10);
    chk_beats("t4b", rb + 10, 'h700, 8);
    chk("t4_ovf_after", 32'(ovf_count), 32'd0);

    // drop across the pointer wrap
    apply_reset();
    rb = rx_q.size();
    send_pkt(14, 1'b0, 'h800);
    wait_rx(rb + 14);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_wptr_start", 32'(fifo_wptr), 32'd14);
    wb = wrst_n;
    send_pkt(4, 1'b1, 'h900);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_wrst_pulses", 32'(wrst_n - wb), 32'd1);
    chk("t5_rst_ptr", 32'(last_rst_ptr), 32'd14);
    chk("t5_wptr_rewound", 32'(fifo_wptr), 32'd14);
    send_pkt(2, 1'b0, 'hA00);
    wait_rx(rb + 16);
    chk_beats("t5k", rb + 14, 'hA00, 2);
    chk("t5_wptr_end", 32'(fifo_wptr), 32'd16);

    // reset in the middle of a packet
    in_if.valid = 1'b1;
    in_if.data  = DW'('hB00);
    in_if.eop   = 1'b0;
    in_if.drop  = 1'b0;
    @(posedge clk); #1;
    in_if.data = DW'('hB01);
    reset      = 1'b1;
    @(posedge clk); #1;
    chk("t6_in_ready", 32'(in_if.ready), 32'd0);
    chk("t6_wen", 32'(fifo_wen), 32'd0);
    chk("t6_out_valid", 32'(out_if.valid), 32'd0);
    chk("t6_pkt_count", 32'(pkt_count), 32'd0);
    chk("t6_drop_count", 32'(drop_count), 32'd0);
    chk("t6_wptr", 32'(fifo_wptr), 32'd0);
    reset       = 1'b0;
    in_if.valid = 1'b0;
    @(posedge clk); #1;
    rb = rx_q.size();
    send_pkt(3, 1'b0, 'hC00);
    wait_rx(rb + 3);
    chk_beats("t6f", rb, 'hC00, 3);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_pkt_count_end", 32'(pkt_count), 32'd0);

    // single-beat drops saturate the 2-bit drop counter
    apply_reset();
    rb = rx_q.size();
    wb = wrst_n;
    for (int k = 0; k < 4; k++) send_pkt(1, 1'b1, 'hD00 + k);
    repeat (3) @(posedge clk);
    #1;
    chk("t7_drop_sat", 32'(drop_count), 32'd3);
    chk("t7_wrst_pulses", 32'(wrst_n - wb), 32'd4);
    chk("t7_no_egress", 32'(rx_q.size()), 32'(rb));
    chk("t7_wptr", 32'(fifo_wptr), 32'd0);

    chk("protocol_violations", 32'(viol_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_fifo_ctrl.md
Name: pkt_fifo_ctrl

Overview:
- Store-and-forward packet controller wrapped around one synchronous FIFO instance built with resettable pointers.
- Accepts a beat stream whose last beat carries a keep/drop verdict from the filter. Committed packets become readable; dropped and oversize packets are erased by rewinding the FIFO write pointer.
- Egress only ever sees whole, accepted packets. Sits between the filter decision stage and the egress MAC interface.

Parameters:
ADDR_WIDTH, 11, FIFO address width; must match the FIFO instance (depth 2**ADDR_WIDTH)
DATA_W, 19, payload width; FIFO element width = DATA_W+1 (bit DATA_W = eop flag)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_data  in  DATA_W  ingress beat payload
in_valid  in  1  ingress beat valid
in_eop  in  1  last beat of packet
in_drop  in  1  drop verdict; sampled only on an accepted eop beat
in_ready  out  1  ingress may transfer
out_data  out  DATA_W  egress payload
out_eop  out  1  egress last beat
out_valid  out  1  egress beat valid
out_ready  in  1  egress sink accepts
fifo_wen  out  1  FIFO write enable
fifo_wdata  out  DATA_W+1  {in_eop, in_data}
fifo_full  in  1  FIFO full
fifo_wrst  out  1  FIFO write-pointer reset strobe
fifo_rst_wptr  out  ADDR_WIDTH+1  rewind target
fifo_wptr  in  ADDR_WIDTH+1  current FIFO write pointer
fifo_ren  out  1  FIFO read enable
fifo_rdata  in  DATA_W+1  FIFO registered read data (1-cycle latency from pointer)
pkt_count  out  ADDR_WIDTH+1  committed packets not yet fully read out
drop_count  out  CNT_W  packets dropped by verdict, saturating
ovf_count  out  CNT_W  packets discarded as oversize, saturating

Behaviour:
Reset:
- All outputs 0; both FSMs enter their IDLE states.
- fifo_rrst is tied low by the integrator; the read pointer is never rewound.

Ingress transfer: in_valid && in_ready.

Write FSM states: W_IDLE, W_PKT, W_DISCARD, W_REWIND.
- W_IDLE/W_PKT: in_ready = !fifo_full. Transfer drives fifo_wen=1, fifo_wdata={in_eop,in_data} combinationally.
- First transfer in W_IDLE latches start_ptr <= fifo_wptr. Goes to W_PKT, or resolves immediately if in_eop.
- Eop transfer with in_drop=0 (commit): pkt_count increments next cycle; go to W_IDLE.
- Eop transfer with in_drop=1: drop_count++; go to W_REWIND.
- Oversize: in W_PKT with fifo_full=1 and pkt_count=0, the packet can never fit. ovf_count++; go to W_DISCARD.
- fifo_full=1 with pkt_count>0: hold in_ready=0 until egress drains.
- W_DISCARD: in_ready=1, fifo_wen=0, beats swallowed; on eop transfer go to W_REWIND. The in_drop value is ignored.
- W_REWIND: exactly one cycle; fifo_wrst=1, fifo_rst_wptr=start_ptr, in_ready=0, fifo_wen=0; then W_IDLE.
- fifo_wen and fifo_wrst are never asserted in the same cycle.
- Single-beat packets (eop on first beat) follow the same commit/drop rules.

Read FSM states: R_IDLE, R_FETCH, R_VALID.
- R_IDLE: if pkt_count>0, go to R_FETCH.
- R_FETCH: one bubble cycle so fifo_rdata reflects the current read pointer; then R_VALID.
- R_VALID: out_valid=1, {out_eop,out_data}=fifo_rdata. On out_ready, fifo_ren=1 for that cycle:
  - eop beat: pkt_count decrements; go to R_IDLE.
  - otherwise: go to R_FETCH.
- out_valid falls the cycle after the handshake. Throughput is 1 beat per 2 cycles.
- out_data and out_eop remain stable while out_valid && !out_ready.
- Reads never pass the last committed beat because reads are gated by pkt_count, not by FIFO empty.

pkt_count and counters:
- Commit and eop readout in the same cycle: pkt_count unchanged.
- pkt_count never exceeds 2**ADDR_WIDTH and never underflows.
- drop_count and ovf_count saturate at all-ones.

Pointer arithmetic: ADDR_WIDTH+1 bits, modulo wrap. Rewind across the wrap boundary restores start_ptr exactly.

Reset mid-packet: partial packet is lost; pointers clear; counts return to 0.

Test Plan:
- ADDR_WIDTH=4 (FIFO with no block constraint, depth 16). Write 3 packets of 4 beats, verdict keep, out_ready=1 -> 12 beats out in order. out_eop on beats 4/8/12. pkt_count peaks at 3 and returns to 0. Each beat spaced 2 cycles.
- Keep packet A (3 beats), drop packet B (5 beats), keep packet C (2 beats) -> egress emits A then C only. fifo_wrst pulses once with fifo_rst_wptr equal to wptr at B's first beat. drop_count=1.
- Empty FIFO, 20-beat packet -> fifo_full at beat 16. ovf_count=1; beats 17-20 swallowed with in_ready=1; rewind to 0; next 2-beat keep packet read out correctly.
- FIFO holding a committed 10-beat packet, new 8-beat packet with out_ready=0 -> in_ready=0 at full, no overflow. Release out_ready -> both packets delivered intact.
- Start with wptr=rptr=14 (after traffic); drop a 4-beat packet spanning the wrap -> rewind target 14; following keep packet starts at address 14.
- Assert reset during beat 2 of a packet -> next cycle all outputs 0, pkt_count=0. A fresh packet passes normally.
